// File: rtl/cache_controller.sv
// Two-way set-associative, write-through read cache between the MEM stage and the SRAM controller.
// Loads hit with no stall; misses fetch a 64-bit line; every store goes through to SRAM.
module cache_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_read,
   output logic        sram_write,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

   state_t      state;
   logic [63:0] valid0, valid1, lru;
   logic [9:0]  tag0  [64];
   logic [9:0]  tag1  [64];
   logic [63:0] data0 [64];
   logic [63:0] data1 [64];

   logic [5:0]  idx;
   logic [9:0]  tag;
   logic        word_sel;
   logic        hit0, hit1, hit;
   logic        victim;
   logic [63:0] hit_line;
   logic        load_req, store_req;
   logic        fill, write_done;

   assign idx      = address[8:3];
   assign tag      = address[18:9];
   assign word_sel = address[2];

   assign hit0     = valid0[idx] && (tag0[idx] == tag);
   assign hit1     = valid1[idx] && (tag1[idx] == tag);
   assign hit      = hit0 || hit1;
   assign hit_line = hit0 ? data0[idx] : data1[idx];

   // Fill an empty way before evicting anything; otherwise the lru bit decides.
   assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

   // A simultaneous load+store is handled as a store.
   assign store_req  = MEM_W_EN;
   assign load_req   = MEM_R_EN && !MEM_W_EN;
   assign fill       = (state == READ_MISS) && sram_ready;
   assign write_done = (state == WRITE) && sram_ready;

   assign sram_address = address;
   assign sram_wdata   = wdata;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      ready = 1'b1;
      rdata = 32'h0;
      case (state)
         IDLE: begin
            if (store_req) begin
               ready = 1'b0;
            end else if (load_req) begin
               if (hit) rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
               else     ready = 1'b0;
            end
         end
         READ_MISS: begin
            ready = sram_ready;
            if (sram_ready) rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
         end
         WRITE:   ready = sram_ready;
         default: ready = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sram_read  <= 1'b0;
         sram_write <= 1'b0;
         valid0     <= '0;
         valid1     <= '0;
         lru        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (store_req) begin
                  state      <= WRITE;
                  sram_write <= 1'b1;
               end else if (load_req) begin
                  if (hit) begin
                     lru[idx] <= hit0;
                  end else begin
                     state     <= READ_MISS;
                     sram_read <= 1'b1;
                  end
               end
            end
            READ_MISS: begin
               if (sram_ready) begin
                  state     <= IDLE;
                  sram_read <= 1'b0;
                  if (victim) valid1[idx] <= 1'b1;
                  else        valid0[idx] <= 1'b1;
                  lru[idx]  <= ~victim;
               end
            end
            WRITE: begin
               if (sram_ready) begin
                  state      <= IDLE;
                  sram_write <= 1'b0;
                  if (hit) lru[idx] <= hit0;
               end
            end
            default: begin
               state      <= IDLE;
               sram_read  <= 1'b0;
               sram_write <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits alone make stale contents invisible.
   always_ff @(posedge clk) begin
      if (fill) begin
         if (victim) begin
            tag1[idx]  <= tag;
            data1[idx] <= sram_rdata;
         end else begin
            tag0[idx]  <= tag;
            data0[idx] <= sram_rdata;
         end
      end else if (write_done && hit) begin
         if (hit0) begin
            if (word_sel) data0[idx][63:32] <= wdata;
            else          data0[idx][31:0]  <= wdata;
         end else begin
            if (word_sel) data1[idx][63:32] <= wdata;
            else          data1[idx][31:0]  <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a recency-ordered residency model predicts hit/miss
// and latency, a backing-memory model predicts load data, and a monitor checks each completion.
module tb_cache_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_read;
   logic        sram_write;
   logic [63:0] sram_rdata = '0;
   logic        sram_ready = 1'b0;

   cache_controller dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .wdata        (wdata),
      .MEM_R_EN     (mem_r_en),
      .MEM_W_EN     (mem_w_en),
      .rdata        (rdata),
      .ready        (ready),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_read    (sram_read),
      .sram_write   (sram_write),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_load;
      bit          exp_read;
      bit          exp_write;
      logic [31:0] data;
      int          stalls;
   } exp_t;

   exp_t        sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          ignore   = 1'b0;

   // Memories keyed by line number (address[18:3]); unwritten lines have a fixed pattern.
   logic [63:0] sram_mem [int];
   logic [63:0] ref_mem  [int];
   logic [9:0]  resident [64][$];   // per set, most recently used tag first

   function automatic logic [63:0] init_line(input int ln);
      logic [31:0] a;
      a = ln << 3;
      if (a == 32'h100) return 64'h1111_1111_2222_2222;
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   function automatic logic [63:0] ref_line(input int ln);
      if (ref_mem.exists(ln)) return ref_mem[ln];
      return init_line(ln);
   endfunction

   function automatic logic [63:0] sram_line(input int ln);
      if (sram_mem.exists(ln)) return sram_mem[ln];
      return init_line(ln);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // SRAM controller model: sram_ready in the 6th request cycle, writes land on completion.
   int sram_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         sram_cnt   = 0;
         sram_ready = 1'b0;
      end else if (sram_read || sram_write) begin
         sram_cnt++;
         if (sram_cnt == 6) begin
            int          ln;
            logic [63:0] line;
            ln   = int'(sram_address[18:3]);
            line = sram_line(ln);
            sram_rdata = line;
            sram_ready = 1'b1;
            if (sram_write) begin
               if (sram_address[2]) line[63:32] = sram_wdata;
               else                 line[31:0]  = sram_wdata;
               sram_mem[ln] = line;
            end
         end else begin
            sram_ready = 1'b0;
            sram_rdata = {$urandom, $urandom};
         end
      end else begin
         sram_cnt   = 0;
         sram_ready = 1'b0;
      end
   end

   // Reference model: a set keeps at most two lines; touching a line makes it most recent,
   // a load miss inserts and drops the least recent, stores never allocate.
   function automatic exp_t model_access(input bit rd, input bit wr,
                                         input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      int          s, ln, pos;
      logic [9:0]  tg;
      logic [63:0] line;
      s    = int'(a[8:3]);
      tg   = a[18:9];
      ln   = int'(a[18:3]);
      line = ref_line(ln);
      pos  = -1;
      foreach (resident[s][i]) if (resident[s][i] == tg) pos = i;
      e.is_load   = rd && !wr;
      e.exp_write = wr;
      e.exp_read  = e.is_load && (pos < 0);
      e.stalls    = (e.is_load && pos >= 0) ? 0 : 6;
      e.data      = a[2] ? line[63:32] : line[31:0];
      if (wr) begin
         if (a[2]) line[63:32] = d;
         else      line[31:0]  = d;
         ref_mem[ln] = line;
      end
      if (pos >= 0) begin
         resident[s].delete(pos);
         resident[s].push_front(tg);
      end else if (e.is_load) begin
         resident[s].push_front(tg);
         if (resident[s].size() > 2) void'(resident[s].pop_back());
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 64; s++) resident[s].delete();
   endtask

   // Present one request, wait (bounded) for ready, return just after the completion edge.
   task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      int n;
      sb.push_back(model_access(rd, wr, a, d));
      address  = a;
      wdata    = d;
      mem_r_en = rd;
      mem_w_en = wr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 40);
      if (!ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: ready still %b after %0d cycles, expected 1", ready, n);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int cycles);
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   // Monitor: counts stall cycles per request and pops the scoreboard on completion.
   int stall_cnt = 0;
   bit saw_r = 1'b0, saw_w = 1'b0;
   always @(negedge clk) begin
      if (rst || ignore) begin
         stall_cnt = 0;
         saw_r     = 1'b0;
         saw_w     = 1'b0;
      end else if (mem_r_en || mem_w_en) begin
         saw_r |= sram_read;
         saw_w |= sram_write;
         if (sram_read || sram_write) begin
            check("sram_address", 64'(sram_address), 64'(address));
            if (sram_write) check("sram_wdata", 64'(sram_wdata), 64'(wdata));
         end
         if (!ready) begin
            stall_cnt++;
         end else begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL completion: got a completion, expected none pending");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
               check("sram_read_seen", 64'(saw_r), 64'(e.exp_read));
               check("sram_write_seen", 64'(saw_w), 64'(e.exp_write));
               if (e.is_load) check("rdata", 64'(rdata), 64'(e.data));
            end
            stall_cnt = 0;
            saw_r     = 1'b0;
            saw_w     = 1'b0;
         end
      end else begin
         check("idle_ready", 64'(ready), 64'd1);
         check("idle_sram_req", 64'({sram_read, sram_write}), 64'd0);
      end
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_sram_read", 64'(sram_read), 64'd0);
      check("reset_sram_write", 64'(sram_write), 64'd0);
      check("reset_rdata", 64'(rdata), 64'd0);
      @(posedge clk);
      #2;

      // Cold miss, hit in same line, second tag, LRU eviction in set 32.
      issue(1, 0, 32'h100, 0);
      issue(1, 0, 32'h104, 0);
      issue(1, 0, 32'h300, 0);
      issue(1, 0, 32'h100, 0);
      issue(1, 0, 32'h500, 0);
      issue(1, 0, 32'h100, 0);
      issue(1, 0, 32'h300, 0);
      idle(2);
      // Write hit updates the resident copy; write miss does not allocate.
      issue(0, 1, 32'h104, 32'hDEAD_BEEF);
      issue(1, 0, 32'h104, 0);
      issue(0, 1, 32'h800, 32'h1234_5678);
      issue(1, 0, 32'h800, 0);
      // Both enables act as a store.
      issue(1, 1, 32'h100, 32'hCAFE_F00D);
      issue(1, 0, 32'h100, 0);
      idle(1);

      // Reset during the 3rd READ_MISS cycle; the partial fill must not survive.
      ignore   = 1'b1;
      address  = 32'h900;
      mem_r_en = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_sram_read", 64'(sram_read), 64'd0);
      check("rst_sram_write", 64'(sram_write), 64'd0);
      mem_r_en = 1'b0;
      #1;
      check("rst_ready", 64'(ready), 64'd1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      ignore = 1'b0;
      issue(1, 0, 32'h900, 0);
      issue(1, 0, 32'h100, 0);

      // Randomized traffic over a few sets and tags to exercise hits, evictions and stores.
      for (int k = 0; k < 250; k++) begin
         logic [31:0] a;
         int          r;
         a = ($urandom_range(0, 3) << 9) | (32'($urandom_range(0, 2)) == 0 ? 32'h0 :
             (32'($urandom_range(0, 1)) == 0 ? 32'h8 : 32'h100)) | ($urandom_range(0, 1) << 2);
         r = $urandom_range(0, 9);
         if (r < 6)      issue(1, 0, a, 0);
         else if (r < 9) issue(0, 1, a, $urandom);
         else            issue(1, 1, a, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(3);

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through read cache between the MEM stage and the SRAM controller. It serves 32-bit MEM-stage loads from 64-bit lines held on chip. On a miss it fetches the whole line through the SRAM controller's 64-bit read port. Every store is forwarded to the SRAM controller, and a resident copy is updated on a write hit. It stalls the pipeline through `ready` while an SRAM transaction is in flight.

## Interface
- No parameters: 64 sets × 2 ways × 64-bit line; tag = address[18:9], index = address[8:3], word select = address[2].
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `address`  in  32  MEM-stage byte address, word-aligned; bits [31:19] ignored.
- `wdata`  in  32  store data.
- `MEM_R_EN`  in  1  load request.
- `MEM_W_EN`  in  1  store request.
- `rdata`  out  32  load data, valid while `ready`=1 and `MEM_R_EN`=1.
- `ready`  out  1  0 = stall pipeline.
- `sram_address`  out  32  equals `address`.
- `sram_wdata`  out  32  equals `wdata`.
- `sram_read`  out  1  read request to SRAM controller.
- `sram_write`  out  1  write request to SRAM controller.
- `sram_rdata`  in  64  line from SRAM controller; [31:0] is the word at address[2]=0.
- `sram_ready`  in  1  SRAM controller completion; sampled only while `sram_read` or `sram_write` is high.

## Operation
- Per set: way0 and way1 each hold {valid, tag[9:0], data[63:0]}, plus one `lru` bit naming the way to replace next.
- Hit in way w: valid[w] is set and tag[w] equals address[18:9]. Both ways hitting cannot occur.
- States: IDLE, READ_MISS, WRITE.
- IDLE:
  - No request: `ready`=1.
  - Load hit: `ready`=1 and `rdata` = hit line word[address[2]], combinationally. At the edge, lru = ~w. Stay in IDLE.
  - Load miss: `ready`=0; go to READ_MISS.
  - Store (hit or miss): `ready`=0; go to WRITE.
  - `MEM_R_EN` and `MEM_W_EN` both high: treated as a store.
- READ_MISS:
  - `sram_read`=1.
  - While `sram_ready`=0: `ready`=0.
  - When `sram_ready`=1: `ready`=1 and `rdata` = `sram_rdata` word[address[2]], combinationally.
  - At that edge: fill the victim way with {1, tag, `sram_rdata`}, set lru = ~victim, return to IDLE.
  - Victim: way0 if invalid, else way1 if invalid, else the way named by `lru`.
- WRITE:
  - `sram_write`=1.
  - When `sram_ready`=1: `ready`=1.
  - At that edge, on a hit in way w: replace data[w] word[address[2]] with `wdata` and set lru = ~w.
  - Miss: no allocate, no change to the arrays.
  - Return to IDLE.
- `sram_read`/`sram_write` are decoded from the state register only, never from the request inputs, so they are glitch-free and are both low in IDLE.
- Upstream holds `address`, `wdata` and the enables stable while `ready`=0.

## Timing
- Reset (async): all valid=0, all lru=0, state=IDLE. Outputs then read `ready`=1 when no request is present, `sram_read`=0, `sram_write`=0, `rdata`=0. Tag and data arrays need no reset.
- Load hit: 0-cycle stall; `ready` stays 1.
- Load miss:
  - IDLE cycle, then 6 cycles in READ_MISS (the SRAM controller asserts `sram_ready` in its 6th request cycle).
  - `ready` is low for 6 cycles and high in the 7th cycle counting the request cycle as cycle 1.
- Store: same 7-cycle profile through WRITE.
- Request lines deassert on the same edge that samples `sram_ready`=1. The SRAM controller therefore sees its enable low the next cycle and returns its counter to 0.
- Back-to-back: a new request presented the cycle after completion is handled normally from IDLE.
- Reset mid-transaction: state goes to IDLE immediately. `sram_read`/`sram_write` drop asynchronously. No partial fill is written.

## Test plan
- Cold load 0x0000_0100, `sram_rdata`=0x1111_1111_2222_2222 → `ready` low 6 cycles, high in cycle 7 with `rdata`=0x2222_2222. Then load 0x104 → hit, `rdata`=0x1111_1111, `ready` never low, `sram_read` never asserted.
- Fill 0x100 then 0x300 (set 32, tags 0 and 1), re-read 0x100, then load 0x500 (tag 2) → way holding tag 1 evicted. Load 0x100 hits; load 0x300 misses.
- Store 0x104 = 0xDEAD_BEEF after line 0x100 is resident → `sram_write` high 6 cycles. Subsequent load 0x104 hits with 0xDEAD_BEEF.
- Store to non-resident 0x800 → SRAM write completes in 7 cycles. Next load 0x800 misses (no allocate).
- Assert `rst` during cycle 3 of READ_MISS → `sram_read` low immediately, state IDLE. A load of the same address afterwards misses.
- `MEM_R_EN`=`MEM_W_EN`=1 → WRITE state entered, `sram_read` stays 0.
